// File: rtl/fm_receiver_pkg.sv
// FM receiver shared definitions.
// Datapath widths, output limits and accumulator state encoding.
package fm_receiver_pkg;

    localparam int PROD_W = 30;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 15;

    localparam logic signed [15:0] Q_MAX = 16'sh7fff;
    localparam logic signed [15:0] Q_MIN = 16'sh8000;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;

endpackage

// File: rtl/fm_receiver_round_sat.sv
// Round-half-up, arithmetic shift and saturate a wide sum
// down to a signed OUT_W sample; flags when clipping occurs.
module fm_receiver_round_sat #(
    parameter int ACC_W = 40,
    parameter int SHIFT = 15,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] sum_i,
    output logic signed [OUT_W-1:0] y_o,
    output logic                    sat_o
);

    // One extra bit so the rounding offset can never overflow.
    localparam logic signed [ACC_W:0] RND =
        (ACC_W+1)'(1) << (SHIFT-1);
    localparam logic signed [ACC_W:0] HI =
        {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] LO =
        {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] q;

    // Round, shift, then clip to the output range.
    always_comb begin
        r     = {sum_i[ACC_W-1], sum_i} + RND;
        q     = r >>> SHIFT;
        y_o   = q[OUT_W-1:0];
        sat_o = 1'b0;
        if (q > HI) begin
            y_o   = {1'b0, {(OUT_W-1){1'b1}}};
            sat_o = 1'b1;
        end else if (q < LO) begin
            y_o   = {1'b1, {(OUT_W-1){1'b0}}};
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/fm_receiver_fir_acc.sv
// Channel FIR accumulate-and-requantise stage.
// Sums tap products per sample and presents one rounded output.
module fm_receiver_fir_acc
    import fm_receiver_pkg::*;
#(
    parameter int PROD_W   = fm_receiver_pkg::PROD_W,
    parameter int ACC_W    = 40,
    parameter int OUT_W    = fm_receiver_pkg::OUT_W,
    parameter int SHIFT    = fm_receiver_pkg::SHIFT,
    parameter int MAX_TAPS = 64,
    localparam int CNT_W   = $clog2(MAX_TAPS+1)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    input  logic              prod_last,
    output logic              prod_ready,
    output logic [OUT_W-1:0]  y_out,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              y_sat,
    output logic [CNT_W-1:0]  tap_cnt,
    output logic              err_taps
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;
    logic               rdy_q, rdy_d;

    logic               beat;
    logic               cap;
    logic [ACC_W-1:0]   sum;
    logic [OUT_W-1:0]   rs_y;
    logic               rs_sat;

    assign beat = prod_valid && rdy_q;
    assign cap  = cnt_q == CNT_W'(MAX_TAPS-1);
    assign sum  = acc_q
                + {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};

    fm_receiver_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .sum_i (sum),
        .y_o   (rs_y),
        .sat_o (rs_sat)
    );

    // Next-state: accumulate beats, close a sample, wait for drain.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        sat_d   = sat_q;
        tcnt_d  = tcnt_q;
        vld_d   = vld_q;
        err_d   = err_q;
        unique case (state_q)
            ACC: begin
                if (beat) begin
                    if (prod_last || cap) begin
                        y_d     = rs_y;
                        sat_d   = rs_sat;
                        tcnt_d  = cnt_q + CNT_W'(1);
                        vld_d   = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = OUT;
                        if (!prod_last) err_d = 1'b1;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            OUT: begin
                if (y_ready) begin
                    vld_d   = 1'b0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
        rdy_d = state_d == ACC;
    end

    // State registers; ready stays low while reset is held.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
            tcnt_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
            tcnt_q  <= tcnt_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    assign prod_ready = rdy_q;
    assign y_out      = y_q;
    assign y_valid    = vld_q;
    assign y_sat      = sat_q;
    assign tap_cnt    = tcnt_q;
    assign err_taps   = err_q;

endmodule

// File: tb/tb_fm_receiver_fir_acc.sv
// Directed bench for the FIR accumulate stage (MAX_TAPS=4).
// Expected values are hand-computed from the requantisation rules.
module tb_fm_receiver_fir_acc;
    import fm_receiver_pkg::*;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [29:0] prod_in;
    logic        prod_valid;
    logic        prod_last;
    logic        prod_ready;
    logic [15:0] y_out;
    logic        y_valid;
    logic        y_ready;
    logic        y_sat;
    logic [2:0]  tap_cnt;
    logic        err_taps;

    int passed = 0;
    int total  = 0;

    fm_receiver_fir_acc #(.MAX_TAPS(4)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .y_out      (y_out),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_sat      (y_sat),
        .tap_cnt    (tap_cnt),
        .err_taps   (err_taps)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic beat(input logic [29:0] v, input logic l);
        prod_in    = v;
        prod_last  = l;
        prod_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic drain();
        y_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        y_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge ap_clk);
        #1;
        total++; if (y_valid !== 1'b0) $display("FAIL rst_vld got %b want 0", y_valid); else passed++;
        total++; if (y_out !== 16'd0) $display("FAIL rst_y got %0d want 0", y_out); else passed++;
        total++; if (y_sat !== 1'b0) $display("FAIL rst_sat got %b want 0", y_sat); else passed++;
        total++; if (tap_cnt !== 3'd0) $display("FAIL rst_tap got %0d want 0", tap_cnt); else passed++;
        total++; if (err_taps !== 1'b0) $display("FAIL rst_err got %b want 0", err_taps); else passed++;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        total++; if (prod_ready !== 1'b1) $display("FAIL rst_rdy got %b want 1", prod_ready); else passed++;
    endtask

    task automatic test_single();
        beat(30'd32768, 1'b1);
        total++; if (y_valid !== 1'b1) $display("FAIL one_vld got %b want 1", y_valid); else passed++;
        total++; if (y_out !== 16'd1) $display("FAIL one_y got %0d want 1", y_out); else passed++;
        total++; if (y_sat !== 1'b0) $display("FAIL one_sat got %b want 0", y_sat); else passed++;
        total++; if (tap_cnt !== 3'd1) $display("FAIL one_tap got %0d want 1", tap_cnt); else passed++;
        total++; if (prod_ready !== 1'b0) $display("FAIL one_rdy got %b want 0", prod_ready); else passed++;
        drain();
        total++; if (y_valid !== 1'b0) $display("FAIL one_drop got %b want 0", y_valid); else passed++;
        total++; if (prod_ready !== 1'b1) $display("FAIL one_back got %b want 1", prod_ready); else passed++;
    endtask

    task automatic test_round();
        logic [29:0] v[3];
        logic [15:0] e[3];
        v = '{30'd16384, -30'sd16384, -30'sd16385};
        e = '{16'd1, 16'd0, 16'hffff};
        for (int i = 0; i < 3; i++) begin
            beat(v[i], 1'b1);
            total++; if (y_out !== e[i]) $display("FAIL round%0d got %0d want %0d", i, $signed(y_out), $signed(e[i])); else passed++;
            total++; if (y_sat !== 1'b0) $display("FAIL round%0d_sat got %b want 0", i, y_sat); else passed++;
            drain();
        end
    endtask

    task automatic test_sat();
        repeat (3) beat(30'd536870911, 1'b0);
        beat(30'd536870911, 1'b1);
        total++; if (y_out !== Q_MAX) $display("FAIL satp_y got %0d want 32767", $signed(y_out)); else passed++;
        total++; if (y_sat !== 1'b1) $display("FAIL satp_f got %b want 1", y_sat); else passed++;
        total++; if (tap_cnt !== 3'd4) $display("FAIL satp_tap got %0d want 4", tap_cnt); else passed++;
        total++; if (err_taps !== 1'b0) $display("FAIL satp_err got %b want 0", err_taps); else passed++;
        drain();
        repeat (3) beat(30'h20000000, 1'b0);
        beat(30'h20000000, 1'b1);
        total++; if (y_out !== Q_MIN) $display("FAIL satn_y got %0d want -32768", $signed(y_out)); else passed++;
        total++; if (y_sat !== 1'b1) $display("FAIL satn_f got %b want 1", y_sat); else passed++;
        drain();
    endtask

    task automatic test_backpressure();
        beat(30'd98304, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++; if (y_out !== 16'd3) $display("FAIL bp%0d_y got %0d want 3", i, y_out); else passed++;
            total++; if (prod_ready !== 1'b0) $display("FAIL bp%0d_rdy got %b want 0", i, prod_ready); else passed++;
            total++; if (y_valid !== 1'b1) $display("FAIL bp%0d_vld got %b want 1", i, y_valid); else passed++;
            prod_in    = 30'd12345;
            prod_valid = 1'b1;
            @(posedge ap_clk);
            #1;
        end
        prod_valid = 1'b0;
        total++; if (y_out !== 16'd3) $display("FAIL bp_last_y got %0d want 3", y_out); else passed++;
        drain();
        total++; if (y_valid !== 1'b0) $display("FAIL bp_drop got %b want 0", y_valid); else passed++;
        total++; if (prod_ready !== 1'b1) $display("FAIL bp_back got %b want 1", prod_ready); else passed++;
        beat(30'd32768, 1'b1);
        total++; if (y_out !== 16'd1) $display("FAIL bp_next_y got %0d want 1", y_out); else passed++;
        total++; if (tap_cnt !== 3'd1) $display("FAIL bp_next_tap got %0d want 1", tap_cnt); else passed++;
        drain();
    endtask

    task automatic test_bubble();
        beat(30'd32768, 1'b0);
        prod_last = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        prod_last = 1'b0;
        total++; if (y_valid !== 1'b0) $display("FAIL bub_vld got %b want 0", y_valid); else passed++;
        beat(30'd32768, 1'b1);
        total++; if (y_out !== 16'd2) $display("FAIL bub_y got %0d want 2", y_out); else passed++;
        total++; if (tap_cnt !== 3'd2) $display("FAIL bub_tap got %0d want 2", tap_cnt); else passed++;
        drain();
    endtask

    task automatic test_forced();
        repeat (3) beat(30'd32768, 1'b0);
        total++; if (y_valid !== 1'b0) $display("FAIL frc3_vld got %b want 0", y_valid); else passed++;
        beat(30'd32768, 1'b0);
        total++; if (y_valid !== 1'b1) $display("FAIL frc_vld got %b want 1", y_valid); else passed++;
        total++; if (y_out !== 16'd4) $display("FAIL frc_y got %0d want 4", y_out); else passed++;
        total++; if (tap_cnt !== 3'd4) $display("FAIL frc_tap got %0d want 4", tap_cnt); else passed++;
        total++; if (err_taps !== 1'b1) $display("FAIL frc_err got %b want 1", err_taps); else passed++;
        drain();
        beat(30'd32768, 1'b1);
        total++; if (y_out !== 16'd1) $display("FAIL frc5_y got %0d want 1", y_out); else passed++;
        total++; if (tap_cnt !== 3'd1) $display("FAIL frc5_tap got %0d want 1", tap_cnt); else passed++;
        total++; if (err_taps !== 1'b1) $display("FAIL frc5_err got %b want 1", err_taps); else passed++;
        drain();
    endtask

    task automatic test_reset_mid();
        beat(30'd32768, 1'b0);
        beat(30'd32768, 1'b0);
        ap_rst_n = 1'b0;
        #1;
        total++; if (y_valid !== 1'b0) $display("FAIL rmid_vld got %b want 0", y_valid); else passed++;
        total++; if (err_taps !== 1'b0) $display("FAIL rmid_err got %b want 0", err_taps); else passed++;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        beat(30'd32768, 1'b1);
        total++; if (y_valid !== 1'b1) $display("FAIL rmid_ovld got %b want 1", y_valid); else passed++;
        total++; if (y_out !== 16'd1) $display("FAIL rmid_y got %0d want 1", y_out); else passed++;
        total++; if (tap_cnt !== 3'd1) $display("FAIL rmid_tap got %0d want 1", tap_cnt); else passed++;
        drain();
    endtask

    initial begin
        ap_rst_n   = 1'b0;
        prod_in    = '0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        y_ready    = 1'b0;
        test_reset();
        test_single();
        test_round();
        test_sat();
        test_backpressure();
        test_bubble();
        test_forced();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
